// File: rtl/seg_digit_scanner.sv
// Time-multiplexed BCD digit scanner feeding a shared seven-segment decoder.
// Optional leading-zero blanking is enabled by defining SEG_LEADING_ZERO_BLANK_EN.
module seg_digit_scanner #(
   parameter int NUM_DIGITS       = 4,
   parameter int REFRESH_DIV      = 50000,
   parameter bit ANODE_ACTIVE_LOW = 1'b1,
   localparam int IDX_W           = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] value,
   output logic [3:0]              num,
   output logic [NUM_DIGITS-1:0]   an,
   output logic [IDX_W-1:0]        digit_idx,
   output logic                    frame_done
);

   localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

   logic [CNT_W-1:0]          div_cnt_reg;
   logic [IDX_W-1:0]          idx_reg;
   logic [4*NUM_DIGITS-1:0]   shadow_reg;
   logic [4*NUM_DIGITS-1:0]   disp_reg;
   logic                      pending_reg;

   logic                      tick;
   logic                      last_digit;
   logic [3:0]                nib      [NUM_DIGITS];
   logic [NUM_DIGITS-1:0]     blank;
   logic [NUM_DIGITS-1:0]     an_sel;
   logic [3:0]                num_next;

   assign tick       = (div_cnt_reg == CNT_W'(REFRESH_DIV - 1));
   assign last_digit = (idx_reg == IDX_W'(NUM_DIGITS - 1));

   // Prescaler, scan index and the shadow/display double buffer.
   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt_reg <= '0;
         idx_reg     <= '0;
         shadow_reg  <= '0;
         disp_reg    <= '0;
         pending_reg <= 1'b0;
      end else begin
         div_cnt_reg <= tick ? '0 : div_cnt_reg + 1'b1;
         if (tick)
            idx_reg <= last_digit ? '0 : idx_reg + 1'b1;
         // A load colliding with a commit still leaves the new word pending.
         if (tick && last_digit && pending_reg) begin
            disp_reg    <= shadow_reg;
            pending_reg <= 1'b0;
         end
         if (load) begin
            shadow_reg  <= value;
            pending_reg <= 1'b1;
         end
      end
   end

   generate
      for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
         assign nib[gi] = disp_reg[4*gi +: 4];
`ifdef SEG_LEADING_ZERO_BLANK_EN
         if (gi == 0) begin : g_first
            assign blank[gi] = 1'b0;
         end else begin : g_upper
            assign blank[gi] = ~|disp_reg[4*NUM_DIGITS-1:4*gi];
         end
`else
         assign blank[gi] = 1'b0;
`endif
      end
   endgenerate

   always_comb begin
      num_next = nib[idx_reg];
      if (blank[idx_reg])
         num_next = 4'hF;
      an_sel = NUM_DIGITS'(1) << idx_reg;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         num        <= 4'hF;
         an         <= ANODE_ACTIVE_LOW ? '1 : '0;
         digit_idx  <= '0;
         frame_done <= 1'b0;
      end else begin
         num        <= num_next;
         an         <= ANODE_ACTIVE_LOW ? ~an_sel : an_sel;
         digit_idx  <= idx_reg;
         frame_done <= tick && last_digit;
      end
   end

endmodule

// File: tb/tb_seg_digit_scanner.sv
// Randomized bench for seg_digit_scanner: two instances (slow active-low, fast active-high)
// checked each cycle against a frame-arithmetic reference model.
module tb_seg_digit_scanner;

   localparam int N = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        load = 1'b0;
   logic [15:0] value = '0;

   logic [3:0]  num0, num1;
   logic [3:0]  an0, an1;
   logic [1:0]  didx0, didx1;
   logic        fd0, fd1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   seg_digit_scanner #(.NUM_DIGITS(N), .REFRESH_DIV(3), .ANODE_ACTIVE_LOW(1'b1)) dut0 (
      .clk(clk), .rst(rst), .load(load), .value(value),
      .num(num0), .an(an0), .digit_idx(didx0), .frame_done(fd0));

   seg_digit_scanner #(.NUM_DIGITS(N), .REFRESH_DIV(1), .ANODE_ACTIVE_LOW(1'b0)) dut1 (
      .clk(clk), .rst(rst), .load(load), .value(value),
      .num(num1), .an(an1), .digit_idx(didx1), .frame_done(fd1));

   // Reference state per instance: edges since reset release and the buffered words.
   int          div_m   [2] = '{3, 1};
   bit          low_m   [2] = '{1'b1, 1'b0};
   int          cyc_m   [2];
   logic [15:0] shadow_m[2];
   logic [15:0] disp_m  [2];
   bit          pend_m  [2];
   logic [3:0]  exp_num [2];
   logic [3:0]  exp_an  [2];
   logic [1:0]  exp_idx [2];
   logic        exp_fd  [2];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [3:0] shown_nibble(input logic [15:0] d, input int k);
      logic [3:0] n;
      n = 4'((d >> (4*k)) & 16'hF);
`ifdef SEG_LEADING_ZERO_BLANK_EN
      if (k > 0 && (d >> (4*k)) == 16'h0)
         n = 4'hF;
`endif
      return n;
   endfunction

   task automatic model_edge(input int i);
      logic [15:0] shown;
      int          k;
      if (rst) begin
         cyc_m[i] = 0; shadow_m[i] = '0; disp_m[i] = '0; pend_m[i] = 1'b0;
         exp_num[i] = 4'hF;
         exp_an[i]  = low_m[i] ? 4'hF : 4'h0;
         exp_idx[i] = 2'd0;
         exp_fd[i]  = 1'b0;
      end else begin
         cyc_m[i]++;
         shown = disp_m[i];
         // Frame boundary: the word pending before this edge becomes visible.
         if (cyc_m[i] % (div_m[i]*N) == 0 && pend_m[i]) begin
            disp_m[i] = shadow_m[i];
            pend_m[i] = 1'b0;
         end
         if (load) begin
            shadow_m[i] = value;
            pend_m[i]   = 1'b1;
         end
         k = ((cyc_m[i] - 1) / div_m[i]) % N;
         exp_num[i] = shown_nibble(shown, k);
         exp_an[i]  = low_m[i] ? ~(4'b1 << k) : (4'b1 << k);
         exp_idx[i] = 2'(k);
         exp_fd[i]  = (cyc_m[i] % (div_m[i]*N) == 0);
      end
   endtask

   task automatic step(input logic r, input logic l, input logic [15:0] v);
      rst = r; load = l; value = v;
      @(posedge clk);
      model_edge(0);
      model_edge(1);
      #1;
      check("num0", 32'(num0), 32'(exp_num[0]));
      check("an0", 32'(an0), 32'(exp_an[0]));
      check("idx0", 32'(didx0), 32'(exp_idx[0]));
      check("fd0", 32'(fd0), 32'(exp_fd[0]));
      check("num1", 32'(num1), 32'(exp_num[1]));
      check("an1", 32'(an1), 32'(exp_an[1]));
      check("idx1", 32'(didx1), 32'(exp_idx[1]));
      check("fd1", 32'(fd1), 32'(exp_fd[1]));
      $display("cyc rst=%0b load=%0b value=%h | dut0 num=%h an=%b fd=%0b | dut1 num=%h an=%b fd=%0b",
               r, l, v, num0, an0, fd0, num1, an1, fd1);
   endtask

   task automatic idle(input int n);
      for (int j = 0; j < n; j++) step(1'b0, 1'b0, 16'h0);
   endtask

   initial begin
      logic [15:0] v;
      // Reset with a simultaneous load that must be ignored.
      step(1'b1, 1'b0, 16'h0);
      step(1'b1, 1'b1, 16'hABCD);
      // Load during the digit-1 slot, then a colliding load on the wrap edge.
      idle(3);
      step(1'b0, 1'b1, 16'h1234);
      idle(7);
      step(1'b0, 1'b1, 16'h5678);
      idle(30);
      // Pending load lost to a mid-frame reset.
      step(1'b0, 1'b1, 16'h9999);
      step(1'b1, 1'b0, 16'h0);
      idle(26);
      step(1'b0, 1'b1, 16'h0040);
      idle(26);
      step(1'b0, 1'b1, 16'h0000);
      idle(26);
      step(1'b0, 1'b1, 16'h0305);
      idle(26);
      for (int j = 0; j < 2500; j++) begin
         v = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
         if ($urandom_range(0, 299) == 0)
            step(1'b1, ($urandom_range(0, 1) == 1), v);
         else
            step(1'b0, ($urandom_range(0, 7) == 0), v);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
